// File: rtl/fir_mac_sequencer_pkg.sv
// Shared constants for the time-multiplexed FIR MAC sequencer: word width,
// FSM state encodings and the saturation limits of the 2N-bit datapath.
`ifndef N
`define N 16
`endif

package fir_mac_sequencer_pkg;
  localparam int N = `N;
  localparam int W = 2 * N;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit W-2 is the effective sign, so the usable range stops one bit short.
  localparam logic [W-1:0] POS_LIM = {2'b00, {(W-2){1'b1}}};
  localparam logic [W-1:0] NEG_LIM = {2'b11, {(W-2){1'b0}}};
endpackage

// File: rtl/fir_mac_sequencer_mac_sat_step.sv
// One combinational multiply-accumulate step with product clamp and
// saturating add; sat reports that either limit was hit in this step.
module mac_sat_step
  import fir_mac_sequencer_pkg::*;
(
  input  logic [N-1:0] x,
  input  logic [N-1:0] c,
  input  logic [W-1:0] acc,
  output logic [W-1:0] acc_next,
  output logic         sat
);

  logic signed [W-1:0] xs, cs, prod;
  logic [W-1:0] prod_sat, sum;
  logic prod_clamp, pos_ovf, neg_ovf;

  always_comb begin
    xs = {{N{x[N-1]}}, x};
    cs = {{N{c[N-1]}}, c};
    prod = xs * cs;
    // Only (-2^(N-1))^2 lands at 2^(W-2), which is positive with bit W-2 set.
    prod_clamp = !prod[W-1] && prod[W-2];
    prod_sat = prod_clamp ? POS_LIM : prod;
    sum = acc + prod_sat;
    pos_ovf = !acc[W-2] && !prod_sat[W-2] && sum[W-2];
    neg_ovf = acc[W-2] && prod_sat[W-2] && !sum[W-2];
    acc_next = pos_ovf ? POS_LIM : (neg_ovf ? NEG_LIM : sum);
    sat = prod_clamp | pos_ovf | neg_ovf;
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller sharing one saturating MAC across all taps, one result per
// sample. Define FIR_SAT_FLAG_EN to build the sticky saturation flag.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [N-1:0]  sample_in,
  output logic          sample_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_wdata,
  output logic          y_valid,
  output logic [W-1:0]  y_out,
  output logic          busy,
  output logic          sat_flag
);

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t        state;
  logic [N-1:0]  x [TAPS];
  logic [N-1:0]  c [TAPS];
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [AW-1:0] k;
  logic          step_sat;

  mac_sat_step u_step (
    .x        (x[k]),
    .c        (c[k]),
    .acc      (acc),
    .acc_next (acc_next),
    .sat      (step_sat)
  );

  // The result is registered on the last MAC edge so it is visible in DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      k            <= '0;
      y_out        <= '0;
      y_valid      <= 1'b0;
      busy         <= 1'b0;
      sample_ready <= 1'b1;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coef_we) c[coef_addr] <= coef_wdata;
          if (sample_valid) begin
            for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            x[0]         <= sample_in;
            acc          <= '0;
            k            <= '0;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
            state        <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (k == LAST) begin
            y_out   <= acc_next;
            y_valid <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy         <= 1'b0;
          sample_ready <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIR_SAT_FLAG_EN
  logic sat_sticky;
  logic sat_out;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_sticky <= 1'b0;
      sat_out    <= 1'b0;
    end else if (state == ST_IDLE && sample_valid) begin
      sat_sticky <= 1'b0;
    end else if (state == ST_MAC) begin
      sat_sticky <= sat_sticky | step_sat;
      if (k == LAST) sat_out <= sat_sticky | step_sat;
    end
  end

  assign sat_flag = sat_out;
`else
  logic unused_step_sat;
  assign unused_step_sat = step_sat;
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a per-cycle reference model plus
// directed vectors with hand-computed results. Honours FIR_SAT_FLAG_EN.
module tb_fir_mac_sequencer;
  import fir_mac_sequencer_pkg::*;

  localparam int TAPS = 8;
  localparam int AW = 3;
  localparam longint PMAX = (longint'(1) <<< (W - 2)) - 1;
  localparam longint PMIN = -(longint'(1) <<< (W - 2));
`ifdef FIR_SAT_FLAG_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_valid;
  logic [N-1:0]  sample_in;
  logic          sample_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_wdata;
  logic          y_valid;
  logic [W-1:0]  y_out;
  logic          busy;
  logic          sat_flag;

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .y_valid      (y_valid),
    .y_out        (y_out),
    .busy         (busy),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: sample history, coefficient table and a cycle phase
  // counted from the accepting edge (0 = idle, TAPS+1 = result cycle).
  shortint     m_x [TAPS];
  shortint     m_c [TAPS];
  int          phase = 0;
  bit          live = 1'b0;
  logic [W-1:0] exp_y = '0;
  logic [W-1:0] pend_y = '0;
  bit          exp_sat = 1'b0;
  bit          pend_sat = 1'b0;
  longint      my;
  bit          ms;

  function automatic void model_compute(output longint y, output bit s);
    longint a;
    longint p;
    a = 0;
    s = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      p = longint'(m_x[i]) * longint'(m_c[i]);
      if (p > PMAX) begin p = PMAX; s = 1'b1; end
      a = a + p;
      if (a > PMAX) begin a = PMAX; s = 1'b1; end
      else if (a < PMIN) begin a = PMIN; s = 1'b1; end
    end
    y = a;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      live = 1'b1;
      phase = 0;
      for (int i = 0; i < TAPS; i++) begin
        m_x[i] = 0;
        m_c[i] = 0;
      end
      exp_y = '0;
      exp_sat = 1'b0;
    end else if (live) begin
      if (phase == 0) begin
        if (coef_we) m_c[coef_addr] = coef_wdata;
        if (sample_valid) begin
          for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
          m_x[0] = sample_in;
          model_compute(my, ms);
          pend_y = my[W-1:0];
          pend_sat = ms;
          phase = 1;
        end
      end else if (phase == TAPS + 1) begin
        phase = 0;
      end else begin
        phase++;
        if (phase == TAPS + 1) begin
          exp_y = pend_y;
          exp_sat = SAT_EN & pend_sat;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checkOutput("cyc_sample_ready", 32'(sample_ready), 32'(phase == 0));
      checkOutput("cyc_busy", 32'(busy), 32'(phase != 0));
      checkOutput("cyc_y_valid", 32'(y_valid), 32'(phase == TAPS + 1));
      checkOutput("cyc_y_out", y_out, exp_y);
      checkOutput("cyc_sat_flag", 32'(sat_flag), 32'(exp_sat));
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!sample_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) checkOutput("ready_timeout", 32'(sample_ready), 32'd1);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
    wait_ready();
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic send_sample(input logic [N-1:0] s);
    wait_ready();
    sample_valid = 1'b1;
    sample_in = s;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] y, output bit sf);
    int lat;
    lat = -1;
    y = '0;
    sf = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (y_valid) begin
        y = y_out;
        sf = sat_flag;
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(TAPS + 1));
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, output logic [W-1:0] y, output bit sf);
    send_sample(s);
    wait_result(y, sf);
  endtask

  logic [W-1:0] y;
  bit sf;
  int vcount;

  initial begin
    reset_n = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(sample_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_y_out", y_out, 32'd0);

    $display("[TB] single-tap gain");
    write_coef(3'd0, 16'h0100);
    applyStimulus(16'h0200, y, sf);
    checkOutput("gain_y", y, 32'h0002_0000);
    checkOutput("gain_sat", 32'(sf), 32'd0);

    $display("[TB] impulse response");
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'(i + 1));
    for (int j = 0; j <= TAPS; j++) begin
      applyStimulus((j == 0) ? 16'h0001 : 16'h0000, y, sf);
      checkOutput("impulse_y", y, (j < TAPS) ? 32'(j + 1) : 32'd0);
    end

    $display("[TB] positive saturation");
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'h7FFF);
    for (int j = 0; j < TAPS; j++) begin
      applyStimulus(16'h7FFF, y, sf);
      if (j == 0) begin
        checkOutput("pos_first_y", y, 32'h3FFF_0001);
        checkOutput("pos_first_sat", 32'(sf), 32'd0);
      end
    end
    checkOutput("pos_last_y", y, 32'h3FFF_FFFF);
    checkOutput("pos_last_sat", 32'(sf), 32'(SAT_EN));

    $display("[TB] negative saturation");
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'h7FFF);
    for (int j = 0; j < TAPS; j++) begin
      applyStimulus(16'h8000, y, sf);
      if (j == 0) checkOutput("neg_first_y", y, 32'hC000_8000);
    end
    checkOutput("neg_last_y", y, 32'hC000_0000);
    checkOutput("neg_last_sat", 32'(sf), 32'(SAT_EN));

    $display("[TB] product corner");
    do_reset();
    write_coef(3'd0, 16'h8000);
    applyStimulus(16'h8000, y, sf);
    checkOutput("corner_y", y, 32'h3FFF_FFFF);
    checkOutput("corner_sat", 32'(sf), 32'(SAT_EN));

    $display("[TB] busy protection");
    do_reset();
    write_coef(3'd0, 16'h0100);
    write_coef(3'd1, 16'h0001);
    send_sample(16'h0200);
    repeat (3) @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'h1234;
    coef_we = 1'b1;
    coef_addr = 3'd7;
    coef_wdata = 16'h7FFF;
    @(negedge clk);
    checkOutput("busy_ready_a", 32'(sample_ready), 32'd0);
    @(negedge clk);
    checkOutput("busy_ready_b", 32'(sample_ready), 32'd0);
    sample_valid = 1'b0;
    coef_we = 1'b0;
    wait_result(y, sf);
    checkOutput("busy_y", y, 32'h0002_0000);
    applyStimulus(16'h0000, y, sf);
    checkOutput("busy_not_consumed", y, 32'h0000_0200);
    for (int j = 0; j < TAPS - 2; j++) applyStimulus(16'h0000, y, sf);
    checkOutput("busy_c7_kept", y, 32'd0);

    $display("[TB] reset mid-MAC");
    send_sample(16'h0100);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(sample_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_y_out", y_out, 32'd0);
    reset_n = 1'b1;
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (y_valid) vcount++;
    end
    checkOutput("midrst_no_y_valid", 32'(vcount), 32'd0);
    applyStimulus(16'h7FFF, y, sf);
    checkOutput("midrst_coef_zero", y, 32'd0);
    for (int i = 0; i < TAPS; i++) write_coef(3'(i), 16'h0001);
    applyStimulus(16'h0000, y, sf);
    checkOutput("midrst_x_zero", y, 32'h0000_7FFF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run still active at 1000000 time units, required to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
